// File: rtl/calc_core.sv
// Arithmetic engine of the binary calculator: add/sub in one step, shift-add multiply and
// restoring divide one bit per clock; the 16-bit result is presented as four hex digits.
module calc_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       dig0,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [RW-1:0]    r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [RW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_result;
    logic             r_err;

    logic             w_lastIter;
    logic             w_divZero;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [RW-1:0]    w_mulAcc;
    logic [WIDTH:0]   w_remShift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;

    assign w_lastIter = (r_cnt == LAST_ITER);
    assign w_divZero  = (r_opB == '0);
    assign w_sum      = {1'b0, r_opA[WIDTH-1:0]} + {1'b0, r_opB};
    assign w_diff     = {1'b0, r_opA[WIDTH-1:0]} - {1'b0, r_opB};
    assign w_mulAcc   = r_acc + (r_opB[0] ? r_opA : '0);

    // Restoring divide: remainder lives in r_acc low half, dividend/quotient shifts through r_opA low half.
    assign w_remShift = {r_acc[WIDTH-1:0], r_opA[WIDTH-1]};
    assign w_trial    = w_remShift - {1'b0, r_opB};
    assign w_remNext  = w_trial[WIDTH] ? w_remShift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quoNext  = {r_opA[WIDTH-2:0], ~w_trial[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if ((r_op == OP_ADD) || (r_op == OP_SUB) ||
                    ((r_op == OP_DIV) && w_divZero) || w_lastIter) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CALC) || (r_state == S_DONE);
        done = (r_state == S_DONE);
    end

    // r_result is only written on the edge that enters DONE, so the digits never show partial work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_ADD;
            r_opA    <= '0;
            r_opB    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_opA <= {{(RW-WIDTH){1'b0}}, opa};
                        r_opB <= opb;
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_CALC: begin
                    case (r_op)
                        OP_ADD: r_result <= {{(RW-WIDTH-1){1'b0}}, w_sum};
                        OP_SUB: r_result <= {{(RW-WIDTH-1){w_diff[WIDTH]}}, w_diff};
                        OP_MUL: begin
                            r_acc <= w_mulAcc;
                            r_opA <= {r_opA[RW-2:0], 1'b0};
                            r_opB <= {1'b0, r_opB[WIDTH-1:1]};
                            r_cnt <= r_cnt + CW'(1);
                            if (w_lastIter) begin
                                r_result <= w_mulAcc;
                            end
                        end
                        default: begin
                            if (w_divZero) begin
                                r_result <= {(RW/4){4'hE}};
                                r_err    <= 1'b1;
                            end else begin
                                r_acc[WIDTH-1:0] <= w_remNext;
                                r_opA[WIDTH-1:0] <= w_quoNext;
                                r_cnt            <= r_cnt + CW'(1);
                                if (w_lastIter) begin
                                    r_result <= {w_remNext, w_quoNext};
                                end
                            end
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign err  = r_err;
    assign dig0 = r_result[3:0];
    assign dig1 = r_result[7:4];
    assign dig2 = r_result[11:8];
    assign dig3 = r_result[15:12];

endmodule
